// File: rtl/bsg_manycore_link_to_axil_pkg.sv
// Shared register offsets, AXI-Lite response codes and FSM state types for the
// manycore-link AXI-Lite TX control block.
package bsg_manycore_link_to_axil_pkg;

  // Register offsets, decoded from addr[7:0] only
  localparam logic [7:0] TDR_OFFSET  = 8'h00;  // TX data, write-only
  localparam logic [7:0] TDFV_OFFSET = 8'h04;  // TX request free slots, read-only
  localparam logic [7:0] RDR_OFFSET  = 8'h10;  // RX data (response head), read-only
  localparam logic [7:0] RDFO_OFFSET = 8'h14;  // RX occupancy (0/1), read-only

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_PUSH, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_RESP} rd_state_e;

endpackage

// File: rtl/bsg_mcl_axil_tx_ctrl.sv
// AXI-Lite slave that fronts the TX request/response FIFOs of a manycore link.
// Writes to TDR push one word into the request FIFO; reads return request-FIFO
// credits (TDFV), response-FIFO head (RDR, pops it) or response-FIFO occupancy (RDFO).
// Ports:
//   clk_i, reset_i                     clock, synchronous active-high reset
//   aw*/w*/b*                          AXI-Lite write address/data/response channels
//   ar*/r*                             AXI-Lite read address/data channels
//   axil_req_o/_v_o/_ready_i           push side of the TX request FIFO
//   axil_rsp_i/_v_i/_yumi_o            pop side of the TX response FIFO
//   req_credits_i                      free-slot count of the TX request FIFO
module bsg_mcl_axil_tx_ctrl
  import bsg_manycore_link_to_axil_pkg::*;
#(
  parameter int axil_data_width_p   = 32,
  parameter int axil_addr_width_p   = 32,
  parameter int req_credits_width_p = 8
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [axil_addr_width_p-1:0]   awaddr_i,
  input  logic                           awvalid_i,
  output logic                           awready_o,
  input  logic [axil_data_width_p-1:0]   wdata_i,
  input  logic [axil_data_width_p/8-1:0] wstrb_i,
  input  logic                           wvalid_i,
  output logic                           wready_o,
  output logic [1:0]                     bresp_o,
  output logic                           bvalid_o,
  input  logic                           bready_i,
  input  logic [axil_addr_width_p-1:0]   araddr_i,
  input  logic                           arvalid_i,
  output logic                           arready_o,
  output logic [axil_data_width_p-1:0]   rdata_o,
  output logic [1:0]                     rresp_o,
  output logic                           rvalid_o,
  input  logic                           rready_i,
  output logic [axil_data_width_p-1:0]   axil_req_o,
  output logic                           axil_req_v_o,
  input  logic                           axil_req_ready_i,
  input  logic [axil_data_width_p-1:0]   axil_rsp_i,
  input  logic                           axil_rsp_v_i,
  output logic                           axil_rsp_yumi_o,
  input  logic [req_credits_width_p-1:0] req_credits_i
);

  // Byte strobes are ignored and only addr[7:0] is decoded.
  logic w_unused;
  assign w_unused = ^{wstrb_i, awaddr_i, araddr_i};

  // ---------------------------------------------------------------- write path
  wr_state_e                    r_wstate, w_wstate_n;
  logic [axil_data_width_p-1:0] r_wdata;
  logic [1:0]                   r_bresp;
  logic                         w_aw_fire;
  logic                         w_aw_tdr;

  assign w_aw_tdr = (awaddr_i[7:0] == TDR_OFFSET);

  always_ff @(posedge clk_i) begin
    if (reset_i) r_wstate <= W_IDLE;
    else         r_wstate <= w_wstate_n;
  end

  always_comb begin
    w_wstate_n = r_wstate;
    unique case (r_wstate)
      W_IDLE: if (w_aw_fire) w_wstate_n = w_aw_tdr ? W_PUSH : W_RESP;
      W_PUSH: if (axil_req_ready_i) w_wstate_n = W_RESP;
      W_RESP: if (bready_i) w_wstate_n = W_IDLE;
      default: w_wstate_n = W_IDLE;
    endcase
  end

  always_comb begin
    w_aw_fire    = (r_wstate == W_IDLE) & awvalid_i & wvalid_i & ~reset_i;
    awready_o    = w_aw_fire;
    wready_o     = w_aw_fire;
    axil_req_v_o = (r_wstate == W_PUSH) & ~reset_i;
    axil_req_o   = reset_i ? '0 : r_wdata;
    bvalid_o     = (r_wstate == W_RESP) & ~reset_i;
    bresp_o      = reset_i ? '0 : r_bresp;
  end

  // Response code is fixed at accept time: a TDR write can only complete OKAY.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wdata <= '0;
      r_bresp <= '0;
    end else if (w_aw_fire) begin
      if (w_aw_tdr) r_wdata <= wdata_i;
      r_bresp <= w_aw_tdr ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // ----------------------------------------------------------------- read path
  rd_state_e                    r_rstate, w_rstate_n;
  logic [axil_data_width_p-1:0] r_rdata, w_rdata_n;
  logic [1:0]                   r_rresp, w_rresp_n;
  logic                         w_ar_fire;
  logic                         w_rsp_pop;

  always_ff @(posedge clk_i) begin
    if (reset_i) r_rstate <= R_IDLE;
    else         r_rstate <= w_rstate_n;
  end

  always_comb begin
    w_rstate_n = r_rstate;
    unique case (r_rstate)
      R_IDLE: if (w_ar_fire) w_rstate_n = R_RESP;
      R_RESP: if (rready_i) w_rstate_n = R_IDLE;
      default: w_rstate_n = R_IDLE;
    endcase
  end

  always_comb begin
    w_ar_fire       = (r_rstate == R_IDLE) & arvalid_i & ~reset_i;
    arready_o       = w_ar_fire;
    axil_rsp_yumi_o = w_ar_fire & w_rsp_pop;
    rvalid_o        = (r_rstate == R_RESP) & ~reset_i;
    rdata_o         = reset_i ? '0 : r_rdata;
    rresp_o         = reset_i ? '0 : r_rresp;
  end

  // Read decode; values are captured at accept so they reflect pre-push state.
  always_comb begin
    w_rdata_n = '0;
    w_rresp_n = RESP_SLVERR;
    w_rsp_pop = 1'b0;
    case (araddr_i[7:0])
      TDFV_OFFSET: begin
        w_rdata_n = axil_data_width_p'(req_credits_i);
        w_rresp_n = RESP_OKAY;
      end
      RDFO_OFFSET: begin
        w_rdata_n = axil_data_width_p'(axil_rsp_v_i);
        w_rresp_n = RESP_OKAY;
      end
      RDR_OFFSET: begin
        if (axil_rsp_v_i) begin
          w_rdata_n = axil_rsp_i;
          w_rresp_n = RESP_OKAY;
          w_rsp_pop = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rdata <= '0;
      r_rresp <= '0;
    end else if (w_ar_fire) begin
      r_rdata <= w_rdata_n;
      r_rresp <= w_rresp_n;
    end
  end

endmodule

// File: tb/tb_bsg_mcl_axil_tx_ctrl.sv
module tb_bsg_mcl_axil_tx_ctrl;

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] awaddr_i, wdata_i, araddr_i, axil_rsp_i;
  logic [3:0]  wstrb_i;
  logic        awvalid_i, wvalid_i, bready_i, arvalid_i, rready_i;
  logic        axil_req_ready_i, axil_rsp_v_i;
  logic [7:0]  req_credits_i;
  logic        awready_o, wready_o, bvalid_o, arready_o, rvalid_o;
  logic [1:0]  bresp_o, rresp_o;
  logic [31:0] rdata_o, axil_req_o;
  logic        axil_req_v_o, axil_rsp_yumi_o;

  bsg_mcl_axil_tx_ctrl dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .awaddr_i         (awaddr_i),
    .awvalid_i        (awvalid_i),
    .awready_o        (awready_o),
    .wdata_i          (wdata_i),
    .wstrb_i          (wstrb_i),
    .wvalid_i         (wvalid_i),
    .wready_o         (wready_o),
    .bresp_o          (bresp_o),
    .bvalid_o         (bvalid_o),
    .bready_i         (bready_i),
    .araddr_i         (araddr_i),
    .arvalid_i        (arvalid_i),
    .arready_o        (arready_o),
    .rdata_o          (rdata_o),
    .rresp_o          (rresp_o),
    .rvalid_o         (rvalid_o),
    .rready_i         (rready_i),
    .axil_req_o       (axil_req_o),
    .axil_req_v_o     (axil_req_v_o),
    .axil_req_ready_i (axil_req_ready_i),
    .axil_rsp_i       (axil_rsp_i),
    .axil_rsp_v_i     (axil_rsp_v_i),
    .axil_rsp_yumi_o  (axil_rsp_yumi_o),
    .req_credits_i    (req_credits_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int push_cnt = 0, exp_push_cnt = 0;
  int yumi_cnt = 0, exp_yumi_cnt = 0;

  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  logic [31:0] exp_req[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks that pending
  // outputs stay stable while stalled.
  logic        pv_b, pv_r, pv_q;
  logic [1:0]  pb;
  logic [33:0] pr;
  logic [31:0] pq;
  initial begin pv_b = 0; pv_r = 0; pv_q = 0; pb = 0; pr = 0; pq = 0; end

  always @(negedge clk_i) begin
    if (reset_i) begin
      pv_b = 0; pv_r = 0; pv_q = 0;
    end else begin
      if (pv_b) begin chk("b_hold", bvalid_o, 1); chk("b_stable", bresp_o, pb); end
      if (pv_r) begin chk("r_hold", rvalid_o, 1); chk("r_stable", {rresp_o, rdata_o}, pr); end
      if (pv_q) begin chk("req_hold", axil_req_v_o, 1); chk("req_stable", axil_req_o, pq); end
      if (bvalid_o && bready_i) begin
        if (exp_b.size() == 0) fail_now("unexpected write response");
        else chk("bresp", bresp_o, exp_b.pop_front());
      end
      if (rvalid_o && rready_i) begin
        if (exp_r.size() == 0) fail_now("unexpected read response");
        else chk("rresp_rdata", {rresp_o, rdata_o}, exp_r.pop_front());
      end
      if (axil_req_v_o && axil_req_ready_i) begin
        push_cnt++;
        if (exp_req.size() == 0) fail_now("unexpected push");
        else chk("push_data", axil_req_o, exp_req.pop_front());
      end
      if (axil_rsp_yumi_o) yumi_cnt++;
      pv_b = bvalid_o && !bready_i;      pb = bresp_o;
      pv_r = rvalid_o && !rready_i;      pr = {rresp_o, rdata_o};
      pv_q = axil_req_v_o && !axil_req_ready_i; pq = axil_req_o;
    end
  end

  // Present write and/or read address; returns 1 time unit after the accept edge.
  task automatic issue(input bit dw, input bit dr, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [31:0] ra);
    bit wdone, rdone;
    int n;
    wdone = !dw;
    rdone = !dr;
    @(posedge clk_i); #1;
    if (dw) begin awaddr_i = wa; wdata_i = wd; awvalid_i = 1; wvalid_i = 1; end
    if (dr) begin araddr_i = ra; arvalid_i = 1; end
    n = 0;
    while (!(wdone && rdone) && n < 50) begin
      @(negedge clk_i);
      if (awvalid_i && awready_o && wready_o) wdone = 1;
      if (arvalid_i && arready_o) rdone = 1;
      @(posedge clk_i); #1;
      if (wdone) begin awvalid_i = 0; wvalid_i = 0; end
      if (rdone) arvalid_i = 0;
      n++;
    end
    if (!(wdone && rdone)) begin
      fail_now("handshake timeout");
      awvalid_i = 0; wvalid_i = 0; arvalid_i = 0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0 || exp_req.size() != 0) && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (exp_b.size() != 0 || exp_r.size() != 0 || exp_req.size() != 0) begin
      fail_now("drain timeout");
      exp_b.delete(); exp_r.delete(); exp_req.delete();
    end
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] cred, input logic rspv,
                    input logic [31:0] rsp, input logic [1:0] er, input logic [31:0] ed,
                    input int yumi);
    req_credits_i = cred;
    axil_rsp_v_i  = rspv;
    axil_rsp_i    = rsp;
    exp_r.push_back({er, ed});
    exp_yumi_cnt += yumi;
    issue(0, 1, 0, 0, a);
    drain();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] er);
    exp_b.push_back(er);
    if (er == OK) begin exp_req.push_back(d); exp_push_cnt++; end
    issue(1, 0, a, d, 0);
    drain();
  endtask

  // Write TDR and read roff in the same cycle with both response channels stalled.
  task automatic concurrent(input logic [31:0] wd, input logic [31:0] roff,
                            input logic [33:0] er);
    bready_i = 0;
    rready_i = 0;
    exp_b.push_back(OK);
    exp_req.push_back(wd);
    exp_push_cnt++;
    exp_r.push_back(er);
    issue(1, 1, 32'h0, wd, roff);
    req_credits_i = req_credits_i - 8'd1;  // the push consumes a credit after the read sampled
    repeat (6) @(negedge clk_i);
    chk("conc_bvalid", bvalid_o, 1);
    chk("conc_rvalid", rvalid_o, 1);
    @(posedge clk_i); #1;
    bready_i = 1;
    rready_i = 1;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1;
    awaddr_i = 32'h08; wdata_i = 32'h1111; wstrb_i = 4'hF; awvalid_i = 1; wvalid_i = 1;
    araddr_i = 32'h14; arvalid_i = 1; bready_i = 1; rready_i = 1;
    axil_req_ready_i = 1; axil_rsp_v_i = 0; axil_rsp_i = 32'h0; req_credits_i = 8'd3;

    // Reset state, with requests pending that must not be accepted
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_awready", awready_o, 0);
    chk("rst_wready", wready_o, 0);
    chk("rst_arready", arready_o, 0);
    chk("rst_bvalid", bvalid_o, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_req_v", axil_req_v_o, 0);
    chk("rst_yumi", axil_rsp_yumi_o, 0);
    chk("rst_resps", {bresp_o, rresp_o}, 0);
    chk("rst_rdata", rdata_o, 0);

    // First accept right after reset release: unmapped write + RDFO read, simultaneously
    exp_b.push_back(ERR);
    exp_r.push_back({OK, 32'h0});
    @(posedge clk_i); #1;
    reset_i = 0;
    @(negedge clk_i);
    chk("post_rst_awready", awready_o, 1);
    chk("post_rst_arready", arready_o, 1);
    @(posedge clk_i); #1;
    awvalid_i = 0; wvalid_i = 0; arvalid_i = 0;
    drain();

    // TDR write held off by req_ready for 3 cycles
    axil_req_ready_i = 0;
    exp_b.push_back(OK);
    exp_req.push_back(32'hDEADBEEF);
    exp_push_cnt++;
    issue(1, 0, 32'h0, 32'hDEADBEEF, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("push_wait_v", axil_req_v_o, 1);
      chk("push_wait_data", axil_req_o, 32'hDEADBEEF);
      chk("push_wait_nob", bvalid_o, 0);
    end
    @(posedge clk_i); #1;
    axil_req_ready_i = 1;
    drain();

    // Write decode
    wr(32'h08, 32'h0000_0001, ERR);
    wr(32'h04, 32'h0000_0002, ERR);
    wr(32'h10, 32'h0000_0003, ERR);
    wr(32'h200, 32'h0BADF00D, OK);   // only addr[7:0] decoded -> TDR

    // Read decode
    rd(32'h04, 8'd5, 0, 32'h0, OK, 32'd5, 0);
    rd(32'h10, 8'd0, 1, 32'h12345678, OK, 32'h12345678, 1);
    rd(32'h10, 8'd0, 0, 32'h12345678, ERR, 32'h0, 0);
    rd(32'h14, 8'd0, 1, 32'h0, OK, 32'h1, 0);
    rd(32'h00, 8'd9, 1, 32'h77, ERR, 32'h0, 0);
    rd(32'h20, 8'd9, 1, 32'h77, ERR, 32'h0, 0);
    rd(32'h104, 8'hFF, 0, 32'h0, OK, 32'hFF, 0);

    // Concurrent write + read with stalled responses
    axil_rsp_v_i = 1;
    axil_rsp_i = 32'hCAFE0001;
    req_credits_i = 8'd7;
    concurrent(32'hA5A5A5A5, 32'h14, {OK, 32'h1});
    req_credits_i = 8'd7;
    concurrent(32'h5A5A5A5A, 32'h04, {OK, 32'h7});

    // Reset during W_PUSH aborts the write
    axil_rsp_v_i = 0;
    axil_req_ready_i = 0;
    issue(1, 0, 32'h0, 32'h00000055, 0);
    @(negedge clk_i);
    chk("abort_in_push", axil_req_v_o, 1);
    @(posedge clk_i); #1;
    reset_i = 1;
    @(negedge clk_i);
    chk("abort_rst_req_v", axil_req_v_o, 0);
    @(posedge clk_i); #1;
    reset_i = 0;
    axil_req_ready_i = 1;
    @(negedge clk_i);
    chk("abort_req_v", axil_req_v_o, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("abort_no_bvalid", bvalid_o, 0);
    end

    chk("push_count", push_cnt, exp_push_cnt);
    chk("yumi_count", yumi_cnt, exp_yumi_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
